// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with variable step, wrap or saturate at the
// limits, a one-cycle carry pulse on every limit crossing, and sticky ovf/unf flags.
module updown_counter_param #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             preload,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] step,
  input  logic             clear,
  input  logic             flag_clr,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             ovf,
  output logic             unf,
  output logic             match
);

  // One extra bit of headroom so count + step never truncates before the compare.
  localparam logic [WIDTH:0] MAX_W   = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] MODULUS = MAX_W + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   count_w;
  logic [WIDTH:0]   step_w;
  logic [WIDTH:0]   eff_step;
  logic [WIDTH:0]   up_sum;
  logic             up_cross;
  logic             dn_cross;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] load_val;

  assign count_w  = {1'b0, count};
  assign step_w   = {1'b0, step};
  assign eff_step = (step_w > MAX_W) ? MAX_W : step_w;
  assign up_sum   = count_w + eff_step;
  assign up_cross = up_sum > MAX_W;
  assign dn_cross = eff_step > count_w;
  assign load_val = ({1'b0, data} > MAX_W) ? MAX_VAL : data;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    step_next = count;
    if (up_down) begin
      if (!up_cross)     step_next = WIDTH'(up_sum);
      else if (SATURATE) step_next = MAX_VAL;
      else               step_next = WIDTH'(up_sum - MODULUS);
    end else begin
      if (!dn_cross)     step_next = WIDTH'(count_w - eff_step);
      else if (SATURATE) step_next = '0;
      else               step_next = WIDTH'(count_w + MODULUS - eff_step);
    end
  end

  // NOTE: state registers use non-blocking assignments; a later assignment in the same block wins, which is how a crossing's flag set overrides flag_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (flag_clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (clear) begin
        count <= '0;
      end else if (preload) begin
        count <= load_val;
      end else if (enable && (step != '0)) begin
        count <= step_next;
        if (up_down && up_cross) begin
          carry <= 1'b1;
          ovf   <= 1'b1;
        end else if (!up_down && dn_cross) begin
          carry <= 1'b1;
          unf   <= 1'b1;
        end
      end
    end
  end

  assign match = (count == cmp_val);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: a wrap and a saturate instance share one
// stimulus stream and are compared every cycle against an arithmetic model.
module tb_updown_counter_param;

  localparam int WIDTH = 8;
  localparam int MAXV  = 99;

  logic             clk = 1'b0;
  logic             reset, enable, up_down, preload, clear, flag_clr;
  logic [WIDTH-1:0] data, step, cmp_val;
  logic [WIDTH-1:0] w_count, s_count;
  logic             w_carry, w_ovf, w_unf, w_match;
  logic             s_carry, s_ovf, s_unf, s_match;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    int c;
    bit cy;
    bit ov;
    bit un;
  } mstate_t;

  mstate_t mw = '{0, 1'b0, 1'b0, 1'b0};
  mstate_t ms = '{0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(WIDTH), .MAX_VAL(8'd99), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .preload(preload),
    .data(data), .step(step), .clear(clear), .flag_clr(flag_clr), .cmp_val(cmp_val),
    .count(w_count), .carry(w_carry), .ovf(w_ovf), .unf(w_unf), .match(w_match)
  );

  updown_counter_param #(.WIDTH(WIDTH), .MAX_VAL(8'd99), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .preload(preload),
    .data(data), .step(step), .clear(clear), .flag_clr(flag_clr), .cmp_val(cmp_val),
    .count(s_count), .carry(s_carry), .ovf(s_ovf), .unf(s_unf), .match(s_match)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Next state derived straight from the rules: priority chain, clamped step,
  // then range test of the plain integer result against 0..MAXV.
  function automatic mstate_t next_state(mstate_t m, bit sat);
    mstate_t n;
    int es, t;
    n = m;
    n.cy = 1'b0;
    if (reset) return '{0, 1'b0, 1'b0, 1'b0};
    if (flag_clr) begin
      n.ov = 1'b0;
      n.un = 1'b0;
    end
    if (clear) begin
      n.c = 0;
    end else if (preload) begin
      n.c = (int'(data) > MAXV) ? MAXV : int'(data);
    end else if (enable && step != 0) begin
      es = (int'(step) > MAXV) ? MAXV : int'(step);
      t  = up_down ? m.c + es : m.c - es;
      if (t > MAXV) begin
        n.c  = sat ? MAXV : t - (MAXV + 1);
        n.cy = 1'b1;
        n.ov = 1'b1;
      end else if (t < 0) begin
        n.c  = sat ? 0 : t + (MAXV + 1);
        n.cy = 1'b1;
        n.un = 1'b1;
      end else begin
        n.c = t;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    mw = next_state(mw, 1'b0);
    ms = next_state(ms, 1'b1);
    if (reset) cmp_en = 1'b1;
    #1;
    if (cmp_en) begin
      check("wrap count", int'(w_count), mw.c);
      check("wrap carry", int'(w_carry), int'(mw.cy));
      check("wrap ovf",   int'(w_ovf),   int'(mw.ov));
      check("wrap unf",   int'(w_unf),   int'(mw.un));
      check("wrap match", int'(w_match), int'(mw.c == int'(cmp_val)));
      check("sat count",  int'(s_count), ms.c);
      check("sat carry",  int'(s_carry), int'(ms.cy));
      check("sat ovf",    int'(s_ovf),   int'(ms.ov));
      check("sat unf",    int'(s_unf),   int'(ms.un));
      check("sat match",  int'(s_match), int'(ms.c == int'(cmp_val)));
    end
  end

  // Apply one cycle of inputs, then return #2 after the capturing edge.
  task automatic op(input bit rst, input bit en, input bit ud, input bit pl,
                    input int d, input int st, input bit cl, input bit fc);
    reset = rst; enable = en; up_down = ud; preload = pl;
    data = WIDTH'(d); step = WIDTH'(st); clear = cl; flag_clr = fc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    cmp_val = 8'd200;
    op(1, 1, 1, 1, 55, 3, 1, 1);
    op(1, 1, 1, 0, 0, 7, 0, 0);
    check("reset count", int'(w_count), 0);
    check("reset flags", int'({w_carry, w_ovf, w_unf, s_carry, s_ovf, s_unf}), 0);

    // Up crossing in wrap mode: 97 + 5 -> 2; saturate clamps to 99
    op(0, 0, 1, 1, 97, 0, 0, 0);
    op(0, 1, 1, 0, 0, 5, 0, 0);
    check("up wrap count", int'(w_count), 2);
    check("up wrap carry", int'(w_carry), 1);
    check("up wrap ovf", int'(w_ovf), 1);
    check("up sat count", int'(s_count), 99);
    op(0, 0, 1, 0, 0, 5, 0, 0);
    check("carry one cycle", int'(w_carry), 0);

    // Down crossing: 3 - 5 -> 98, then flag_clr with no crossing
    op(0, 0, 0, 1, 3, 0, 0, 0);
    op(0, 1, 0, 0, 0, 5, 0, 0);
    check("down wrap count", int'(w_count), 98);
    check("down wrap carry", int'(w_carry), 1);
    check("down wrap unf", int'(w_unf), 1);
    check("down sat count", int'(s_count), 0);
    op(0, 0, 0, 0, 0, 5, 0, 1);
    check("flag_clr ovf", int'(w_ovf), 0);
    check("flag_clr unf", int'(w_unf), 0);

    // Saturate at the top: three steps at 99 keep carry high and count pinned
    op(0, 0, 1, 1, 99, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      op(0, 1, 1, 0, 0, 1, 0, 0);
      check("sat hold count", int'(s_count), 99);
      check("sat hold carry", int'(s_carry), 1);
      check("sat hold ovf", int'(s_ovf), 1);
    end
    check("wrap after 3 ups", int'(w_count), 2);

    // Oversized preload clamps and beats enable; clear beats preload
    op(0, 1, 1, 1, 150, 1, 0, 0);
    check("preload clamp", int'(w_count), 99);
    check("preload no carry", int'(w_carry), 0);
    op(0, 1, 1, 1, 50, 1, 1, 0);
    check("clear over preload", int'(w_count), 0);

    // Reset mid-count, then resume from 0
    op(0, 1, 1, 0, 0, 3, 0, 0);
    op(0, 1, 1, 0, 0, 3, 0, 0);
    check("count 6", int'(w_count), 6);
    op(1, 1, 1, 0, 0, 3, 0, 0);
    check("mid reset count", int'(w_count), 0);
    op(0, 1, 1, 0, 0, 3, 0, 0);
    check("resume count", int'(w_count), 3);

    // Compare output, and a zero step holds
    cmp_val = 8'd12;
    op(0, 0, 1, 1, 12, 0, 0, 0);
    check("match at 12", int'(w_match), 1);
    op(0, 1, 1, 0, 0, 0, 0, 0);
    check("zero step hold", int'(w_count), 12);
    check("zero step carry", int'(w_carry), 0);
    op(0, 1, 1, 0, 0, 1, 0, 0);
    check("match after step", int'(w_match), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cmp_val = ($urandom_range(0, 3) == 0) ? WIDTH'(mw.c) : WIDTH'($urandom_range(0, 255));
      op(($urandom_range(0, 63) == 0),
         ($urandom_range(0, 3) != 0),
         $urandom_range(0, 1),
         ($urandom_range(0, 9) == 0),
         $urandom_range(0, 255),
         ($urandom_range(0, 1) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 255),
         ($urandom_range(0, 19) == 0),
         ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
